ublock_ti_round_ctrl: RTL and testbench

//  Sequencer for the 2-share decomposed-type threshold-implemented uBlock-128/128 datapath.

---
 rtl/ublock_ti_round_ctrl_pkg.sv | 25 ++
 rtl/ublock_ti_round_ctrl_round_counter.sv | 50 +++++
 rtl/ublock_ti_round_ctrl.sv | 147 ++++++++++++++
 tb/tb_ublock_ti_round_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ublock_ti_round_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ublock_ti_round_ctrl_pkg
// Shared definitions for the uBlock-128/128 threshold-implementation round
// sequencer: FSM state encoding, default round count and S-box stage count,
// and the width of the inline S-box stage counter.
// ---------------------------------------------------------------------------
package ublock_ti_round_ctrl_pkg;

    localparam int UBLOCK_ROUNDS       = 16;
    localparam int UBLOCK_SBOX_STAGES  = 2;
    localparam int UBLOCK_CNT_W        = 5;

    // The stage counter covers SBOX_STAGES in 1..4.
    localparam int STG_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SUB   = 3'd2,
        ST_LIN   = 3'd3,
        ST_FINAL = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/ublock_ti_round_ctrl_round_counter.sv
// ---------------------------------------------------------------------------
// ublock_ti_round_ctrl_round_counter
// CNT_W-bit round counter with synchronous clear, increment and a "last"
// flag. Saturates at LAST so the round index can never wrap. Also reusable
// by the key-schedule controller.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clr        synchronous clear to 0 (has priority over inc)
//   inc        advance by one unless already at LAST
//   cnt        current count
//   last       cnt == LAST
// ---------------------------------------------------------------------------
module ublock_ti_round_ctrl_round_counter #(
    parameter int CNT_W = 5,
    parameter int LAST  = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(LAST);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LAST_VAL)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == LAST_VAL);

endmodule

// File: rtl/ublock_ti_round_ctrl.sv
// ---------------------------------------------------------------------------
// ublock_ti_round_ctrl
// Sequencer for the 2-share decomposed-type TI uBlock-128/128 datapath.
// Generates every register enable for the shared state/key registers; it
// carries no share data. All outputs are Moore-decoded from registered state
// so start/abort can never glitch an enable.
// Handshake: start is sampled only while ready=1 (IDLE); a start seen in any
// other state is dropped, not queued. done is a single-cycle pulse marking
// the cycle in which the output shares are valid.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        request one encryption
//   abort        synchronous cancel of a busy run (no done)
//   ready        high only in IDLE
//   busy         high in LOAD, SUB, LIN, FINAL
//   load_we      load input/key shares
//   sbox_en      one-hot enable of S-box register stage
//   lin_we       write linear-layer result into state registers
//   ks_step      advance key schedule (same cycle as lin_we)
//   final_xor    apply last round-key XOR
//   round_idx    current round 0..ROUNDS-1
//   done         1-cycle completion pulse
// ---------------------------------------------------------------------------
module ublock_ti_round_ctrl
    import ublock_ti_round_ctrl_pkg::*;
#(
    parameter int ROUNDS      = UBLOCK_ROUNDS,
    parameter int SBOX_STAGES = UBLOCK_SBOX_STAGES,
    parameter int CNT_W       = UBLOCK_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    output logic                   ready,
    output logic                   busy,
    output logic                   load_we,
    output logic [SBOX_STAGES-1:0] sbox_en,
    output logic                   lin_we,
    output logic                   ks_step,
    output logic                   final_xor,
    output logic [CNT_W-1:0]       round_idx,
    output logic                   done
);

    localparam logic [STG_W-1:0] LAST_STG = STG_W'(SBOX_STAGES - 1);

    state_t           state_q, state_d;
    logic [STG_W-1:0] stage_q, stage_d;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             cnt_last;

    ublock_ti_round_ctrl_round_counter #(
        .CNT_W (CNT_W),
        .LAST  (ROUNDS - 1)
    ) u_round_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .cnt  (round_idx),
        .last (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // abort outranks a simultaneous start
                if (start && !abort) begin
                    state_d = ST_LOAD;
                    stage_d = '0;
                    cnt_clr = 1'b1;
                end
            end
            ST_LOAD: begin
                state_d = ST_SUB;
                stage_d = '0;
            end
            ST_SUB: begin
                if (stage_q == LAST_STG) begin
                    state_d = ST_LIN;
                end else begin
                    stage_d = stage_q + STG_W'(1);
                end
            end
            ST_LIN: begin
                stage_d = '0;
                if (cnt_last) begin
                    state_d = ST_FINAL;
                end else begin
                    state_d = ST_SUB;
                    cnt_inc = 1'b1;
                end
            end
            ST_FINAL: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // abort is ignored here: the result is already valid
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                stage_d = '0;
                cnt_clr = 1'b1;
            end
        endcase

        // Cancel a busy run; overrides whatever the state decided above.
        if (abort && (state_q == ST_LOAD || state_q == ST_SUB ||
                      state_q == ST_LIN  || state_q == ST_FINAL)) begin
            state_d = ST_IDLE;
            stage_d = '0;
            cnt_clr = 1'b1;
            cnt_inc = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_LOAD) || (state_q == ST_SUB) ||
                       (state_q == ST_LIN)  || (state_q == ST_FINAL);
    assign load_we   = (state_q == ST_LOAD);
    assign lin_we    = (state_q == ST_LIN);
    assign ks_step   = (state_q == ST_LIN);
    assign final_xor = (state_q == ST_FINAL);
    assign done      = (state_q == ST_DONE);
    assign sbox_en   = (state_q == ST_SUB) ? (SBOX_STAGES'(1) << stage_q)
                                           : '0;

endmodule

// File: tb/tb_ublock_ti_round_ctrl.sv
module tb_ublock_ti_round_ctrl;

    // Observation vector, shared by both DUT instances.
    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       load;
        logic       lin;
        logic       ks;
        logic       fx;
        logic       done;
        logic [3:0] sbox;
        logic [4:0] rnd;
    } obs_t;

    localparam int RA = 16;
    localparam int SA = 2;
    localparam int RB = 4;
    localparam int SB = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start_a = 1'b0, abort_a = 1'b0;
    logic start_b = 1'b0, abort_b = 1'b0;

    logic       ready_a, busy_a, load_we_a, lin_we_a, ks_step_a, final_xor_a, done_a;
    logic [1:0] sbox_en_a;
    logic [4:0] round_idx_a;
    logic       ready_b, busy_b, load_we_b, lin_we_b, ks_step_b, final_xor_b, done_b;
    logic [2:0] sbox_en_b;
    logic [2:0] round_idx_b;

    ublock_ti_round_ctrl u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .ready(ready_a), .busy(busy_a), .load_we(load_we_a), .sbox_en(sbox_en_a),
        .lin_we(lin_we_a), .ks_step(ks_step_a), .final_xor(final_xor_a),
        .round_idx(round_idx_a), .done(done_a)
    );

    ublock_ti_round_ctrl #(.ROUNDS(RB), .SBOX_STAGES(SB), .CNT_W(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .ready(ready_b), .busy(busy_b), .load_we(load_we_b), .sbox_en(sbox_en_b),
        .lin_we(lin_we_b), .ks_step(ks_step_b), .final_xor(final_xor_b),
        .round_idx(round_idx_b), .done(done_b)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A run is described by t = cycles since the start was accepted:
    // t=0 idle, t=1 load, then ROUNDS blocks of (S sbox cycles + 1 linear
    // cycle), then one final-xor cycle, then one done cycle.
    function automatic int done_time(input int r, input int s);
        return r * (s + 1) + 3;
    endfunction

    function automatic obs_t model_out(input int t, input int r, input int s);
        obs_t o;
        int   u;
        int   dt;
        o  = '0;
        dt = done_time(r, s);
        if (t == 0) begin
            o.ready = 1'b1;
        end else if (t == 1) begin
            o.busy = 1'b1;
            o.load = 1'b1;
        end else if (t < dt - 1) begin
            u      = t - 2;
            o.busy = 1'b1;
            o.rnd  = 5'(u / (s + 1));
            if ((u % (s + 1)) < s) o.sbox = 4'(1 << (u % (s + 1)));
            else begin
                o.lin = 1'b1;
                o.ks  = 1'b1;
            end
        end else if (t == dt - 1) begin
            o.busy = 1'b1;
            o.fx   = 1'b1;
            o.rnd  = 5'(r - 1);
        end else begin
            o.done = 1'b1;
            o.rnd  = 5'(r - 1);
        end
        return o;
    endfunction

    function automatic int model_next(input int t, input int r, input int s,
                                      input logic st, input logic ab);
        if (t == 0) return (st && !ab) ? 1 : 0;
        if (t == done_time(r, s)) return 0;
        if (ab) return 0;
        return t + 1;
    endfunction

    int t_a = 0, t_b = 0;
    int cyc = 0;
    int c0_a = 0, c0_b = 0;
    int ks_a = 0, ks_b = 0;

    function automatic obs_t obs_a();
        return '{ready_a, busy_a, load_we_a, lin_we_a, ks_step_a, final_xor_a,
                 done_a, {2'b0, sbox_en_a}, round_idx_a};
    endfunction

    function automatic obs_t obs_b();
        return '{ready_b, busy_b, load_we_b, lin_we_b, ks_step_b, final_xor_b,
                 done_b, {1'b0, sbox_en_b}, {2'b0, round_idx_b}};
    endfunction

    task automatic dut_checks(input string n, input obs_t act, input int t,
                              input int r, input int s, input int c0,
                              inout int ks_cnt);
        check({n, "_out"}, 32'(act), 32'(model_out(t, r, s)));
        check({n, "_onehot"}, 32'($countones({act.load, act.sbox, act.lin, act.fx}) <= 1), 32'd1);
        if (!act.done) check({n, "_busy_ready"}, 32'(act.busy), 32'(!act.ready));
        if (act.load) ks_cnt = 0;
        if (act.ks) ks_cnt++;
        if (act.done) begin
            check({n, "_ks_count"}, 32'(ks_cnt), 32'(r));
            check({n, "_latency"}, 32'(cyc - c0), 32'(done_time(r, s)));
        end
    endtask

    // One clock: inputs already driven; model follows the posedge,
    // outputs compared at the following negedge.
    task automatic cycle();
        @(posedge clk);
        cyc++;
        if (t_a == 0 && start_a && !abort_a) c0_a = cyc - 1;
        if (t_b == 0 && start_b && !abort_b) c0_b = cyc - 1;
        t_a = model_next(t_a, RA, SA, start_a, abort_a);
        t_b = model_next(t_b, RB, SB, start_b, abort_b);
        @(negedge clk);
        dut_checks("a", obs_a(), t_a, RA, SA, c0_a, ks_a);
        dut_checks("b", obs_b(), t_b, RB, SB, c0_b, ks_b);
    endtask

    int load_cycles[$];

    initial begin
        // ---- reset ----
        repeat (2) @(negedge clk);
        check("rst_a", 32'(obs_a()), 32'(model_out(0, RA, SA)));
        check("rst_b", 32'(obs_b()), 32'(model_out(0, RB, SB)));
        rst = 1'b0;
        @(negedge clk);

        // ---- async reset in LIN of round 5 ----
        start_a = 1'b1;
        start_b = 1'b1;
        cycle();
        start_a = 1'b0;
        start_b = 1'b0;
        for (int i = 0; i < 100 && t_a != 2 + 5 * (SA + 1) + SA; i++) cycle();
        check("reach_lin5", 32'(t_a), 32'(2 + 5 * (SA + 1) + SA));
        check("lin5_we", 32'(lin_we_a), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_a", 32'(obs_a()), 32'(model_out(0, RA, SA)));
        check("async_rst_b", 32'(obs_b()), 32'(model_out(0, RB, SB)));
        t_a = 0;
        t_b = 0;
        @(negedge clk);
        rst = 1'b0;

        // ---- full runs on both instances ----
        start_a = 1'b1;
        start_b = 1'b1;
        cycle();
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (55) cycle();

        // ---- start held high: re-trigger only after returning to IDLE ----
        start_a = 1'b1;
        for (int i = 0; i < 110; i++) begin
            cycle();
            if (load_we_a) load_cycles.push_back(cyc);
        end
        start_a = 1'b0;
        check("held_loads", 32'(load_cycles.size()), 32'd3);
        if (load_cycles.size() >= 2)
            check("held_gap", 32'(load_cycles[1] - load_cycles[0]), 32'(done_time(RA, SA) + 1));
        repeat (60) cycle();

        // ---- abort in round 7, stage 1 ----
        start_a = 1'b1;
        cycle();
        start_a = 1'b0;
        for (int i = 0; i < 100 && t_a != 2 + 7 * (SA + 1) + 1; i++) cycle();
        check("reach_r7s1", 32'(t_a), 32'(2 + 7 * (SA + 1) + 1));
        abort_a = 1'b1;
        cycle();
        check("abort_ready", 32'(ready_a), 32'd1);
        check("abort_round", 32'(round_idx_a), 32'd0);
        start_a = 1'b1;
        cycle();
        check("start_abort_idle", 32'(ready_a), 32'd1);
        start_a = 1'b0;
        abort_a = 1'b0;
        repeat (3) cycle();

        // ---- randomized traffic ----
        for (int i = 0; i < 3000; i++) begin
            start_a = ($urandom_range(0, 3) == 0);
            abort_a = ($urandom_range(0, 79) == 0);
            start_b = ($urandom_range(0, 3) == 0);
            abort_b = ($urandom_range(0, 39) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
